// File: rtl/rtc_bus_cycle_gen_if.sv
// Multiplexed RTC bus: request/handshake side plus pad-level address/data and strobes.
// The master drives requests and the pad input; the slave is the cycle generator.
interface rtc_bus_cycle_gen_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic              rw;
  logic              abort;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] ad_in;
  logic [DATA_W-1:0] ad_out;
  logic              ad_oe;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              done;
  logic              CS;
  logic              RD;
  logic              WR;
  logic              AD;

  modport master (
    output start, rw, abort, addr, wdata, ad_in,
    input  ad_out, ad_oe, rdata, busy, done, CS, RD, WR, AD
  );

  modport slave (
    input  start, rw, abort, addr, wdata, ad_in,
    output ad_out, ad_oe, rdata, busy, done, CS, RD, WR, AD
  );
endinterface

// File: rtl/rtc_bus_cycle_gen.sv
// Generates one address-strobe / data-strobe cycle on a multiplexed RTC bus.
// All pad outputs are decoded from registered state, so no input reaches them combinationally.
module rtc_bus_cycle_gen #(
  parameter int DATA_W = 8,
  parameter int T_SU   = 2,
  parameter int T_PW   = 6,
  parameter int T_HD   = 2,
  parameter int T_GAP  = 4
) (
  input logic                clkL,
  input logic                resetL,
  rtc_bus_cycle_gen_if.slave bus
);

  typedef enum logic [2:0] {IDLE, A_SU, A_PW, A_HD, GAP, D_PW, D_HD, DONE} state_t;

  // Counter load values: a phase of N cycles counts N-1 down to 0.
  localparam logic [7:0] SU_LD  = 8'(T_SU - 1);
  localparam logic [7:0] PW_LD  = 8'(T_PW - 1);
  localparam logic [7:0] HD_LD  = 8'(T_HD - 1);
  localparam logic [7:0] GAP_LD = 8'(T_GAP - 1);

  state_t            stateReg, stateNext;
  logic [7:0]        cntReg, cntNext;
  logic [DATA_W-1:0] addrReg, wdataReg, rdataReg;
  logic              rwReg;
  logic              lastCyc, accept, capture;
  logic              addrPhase, dataPhase;

  always_ff @(posedge clkL or posedge resetL) begin
    if (resetL) begin
      stateReg <= IDLE;
      cntReg   <= '0;
      addrReg  <= '0;
      wdataReg <= '0;
      rwReg    <= 1'b0;
      rdataReg <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      if (accept) begin
        addrReg  <= bus.addr;
        wdataReg <= bus.wdata;
        rwReg    <= bus.rw;
      end
      if (capture) begin
        rdataReg <= bus.ad_in;
      end
    end
  end

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    lastCyc   = (cntReg == 8'd0);
    accept    = (stateReg == IDLE) && bus.start && !bus.abort;
    // An abort in the final read strobe cycle wins over the capture.
    capture   = (stateReg == D_PW) && lastCyc && rwReg && !bus.abort;

    if (stateReg != IDLE && bus.abort) begin
      stateNext = IDLE;
      cntNext   = '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (accept) begin
            stateNext = A_SU;
            cntNext   = SU_LD;
          end
        end
        A_SU: begin
          if (lastCyc) begin
            stateNext = A_PW;
            cntNext   = PW_LD;
          end else begin
            cntNext = cntReg - 8'd1;
          end
        end
        A_PW: begin
          if (lastCyc) begin
            stateNext = A_HD;
            cntNext   = HD_LD;
          end else begin
            cntNext = cntReg - 8'd1;
          end
        end
        A_HD: begin
          if (lastCyc) begin
            stateNext = GAP;
            cntNext   = GAP_LD;
          end else begin
            cntNext = cntReg - 8'd1;
          end
        end
        GAP: begin
          if (lastCyc) begin
            stateNext = D_PW;
            cntNext   = PW_LD;
          end else begin
            cntNext = cntReg - 8'd1;
          end
        end
        D_PW: begin
          if (lastCyc) begin
            stateNext = D_HD;
            cntNext   = HD_LD;
          end else begin
            cntNext = cntReg - 8'd1;
          end
        end
        D_HD: begin
          if (lastCyc) begin
            stateNext = DONE;
            cntNext   = '0;
          end else begin
            cntNext = cntReg - 8'd1;
          end
        end
        DONE: begin
          stateNext = IDLE;
          cntNext   = '0;
        end
        default: begin
          stateNext = IDLE;
          cntNext   = '0;
        end
      endcase
    end
  end

  assign addrPhase = (stateReg == A_SU) || (stateReg == A_PW) || (stateReg == A_HD);
  assign dataPhase = (stateReg == GAP) || (stateReg == D_PW) || (stateReg == D_HD);

  // AD only toggles on entry to A_SU, GAP and IDLE, all of which keep every strobe high.
  assign bus.CS     = !((stateReg == A_PW) || (stateReg == D_PW));
  assign bus.WR     = !((stateReg == A_PW) || ((stateReg == D_PW) && !rwReg));
  assign bus.RD     = !((stateReg == D_PW) && rwReg);
  assign bus.AD     = !addrPhase;
  assign bus.ad_oe  = addrPhase || (dataPhase && !rwReg);
  assign bus.ad_out = addrPhase ? addrReg : wdataReg;
  assign bus.busy   = (stateReg != IDLE);
  assign bus.done   = (stateReg == DONE);
  assign bus.rdata  = rdataReg;

endmodule

// File: tb/tb_rtc_bus_cycle_gen.sv
// Bench for rtc_bus_cycle_gen: default-timing DUT plus an all-ones timing DUT.
// Completed cycles are scored against a queue of expected done cycle and rdata.
module tb_rtc_bus_cycle_gen;

  localparam int         LAT_D     = 23;
  localparam int         LAT_S     = 7;
  localparam logic [6:0] IDLE_PINS = 7'b1111000; // {CS,RD,WR,AD,ad_oe,busy,done}

  logic clkL   = 1'b0;
  logic resetL = 1'b1;
  always #5 clkL = ~clkL;

  int cyc = 0;
  always @(posedge clkL) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic       startReq = 1'b0;
  logic       sel      = 1'b0;
  logic       rwV      = 1'b0;
  logic       abortV   = 1'b0;
  logic [7:0] addrV    = 8'h00;
  logic [7:0] wdataV   = 8'h00;
  logic [7:0] adInV    = 8'h00;
  logic [7:0] expRd    = 8'h00;

  rtc_bus_cycle_gen_if #(.DATA_W(8)) b();
  rtc_bus_cycle_gen_if #(.DATA_W(8)) s();

  assign b.start = startReq & ~sel;
  assign s.start = startReq & sel;
  assign b.rw    = rwV;
  assign s.rw    = rwV;
  assign b.abort = abortV;
  assign s.abort = abortV;
  assign b.addr  = addrV;
  assign s.addr  = addrV;
  assign b.wdata = wdataV;
  assign s.wdata = wdataV;
  assign b.ad_in = adInV;
  assign s.ad_in = adInV;

  rtc_bus_cycle_gen #(.DATA_W(8), .T_SU(2), .T_PW(6), .T_HD(2), .T_GAP(4)) dut (
    .clkL(clkL), .resetL(resetL), .bus(b)
  );
  rtc_bus_cycle_gen #(.DATA_W(8), .T_SU(1), .T_PW(1), .T_HD(1), .T_GAP(1)) dutS (
    .clkL(clkL), .resetL(resetL), .bus(s)
  );

  logic [6:0] pins;
  logic [7:0] adOut, rdataObs;
  assign pins     = sel ? {s.CS, s.RD, s.WR, s.AD, s.ad_oe, s.busy, s.done}
                        : {b.CS, b.RD, b.WR, b.AD, b.ad_oe, b.busy, b.done};
  assign adOut    = sel ? s.ad_out : b.ad_out;
  assign rdataObs = sel ? s.rdata : b.rdata;

  typedef struct {
    int         doneCyc;
    logic [7:0] rdata;
  } exp_t;
  exp_t sb[$];
  exp_t popE;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", tag, got, want, cyc);
    end
  endtask

  // Expected pins for relative cycle r of a cycle started on the selected DUT.
  function automatic logic [6:0] expPins(input int r, input logic rd);
    int su, pw, hd, gp;
    su = sel ? 1 : 2;
    pw = sel ? 1 : 6;
    hd = sel ? 1 : 2;
    gp = sel ? 1 : 4;
    if (r <= su)                     return 7'b1110110;
    if (r <= su + pw)                return 7'b0100110;
    if (r <= su + pw + hd)           return 7'b1110110;
    if (r <= su + pw + hd + gp)      return {4'b1111, ~rd, 2'b10};
    if (r <= su + 2*pw + hd + gp)    return rd ? 7'b0011010 : 7'b0101110;
    if (r <= su + 2*pw + 2*hd + gp)  return {4'b1111, ~rd, 2'b10};
    return IDLE_PINS;
  endfunction

  logic prevAdB = 1'b1;
  logic prevAdS = 1'b1;
  always @(negedge clkL) begin
    if (b.done || s.done) begin
      if (sb.size() == 0) begin
        chk("spuriousDone", 32'd1, 32'd0);
      end else begin
        popE = sb.pop_front();
        chk("doneCyc", cyc, popE.doneCyc);
        chk("doneRdata", rdataObs, popE.rdata);
        $display("txn done cyc=%0d rdata=%0h", cyc, rdataObs);
      end
    end
    chk("adStrobeB", (b.AD !== prevAdB) && !(b.CS && b.RD && b.WR), 0);
    chk("rdWrB", !b.RD && !b.WR, 0);
    chk("adStrobeS", (s.AD !== prevAdS) && !(s.CS && s.RD && s.WR), 0);
    chk("rdWrS", !s.RD && !s.WR, 0);
    prevAdB <= b.AD;
    prevAdS <= s.AD;
  end

  // Caller sits on a negedge; returns on the negedge of relative cycle 1.
  task automatic kick(input logic rw, input logic [7:0] a, input logic [7:0] w, output int c0);
    rwV      = rw;
    addrV    = a;
    wdataV   = w;
    startReq = 1'b1;
    c0       = cyc;
    @(negedge clkL);
    startReq = 1'b0;
  endtask

  task automatic runCycle(input logic rw, input logic [7:0] a, input logic [7:0] w,
                          input logic [7:0] rdVal, input int abortAt, input int resetAt);
    int         c0;
    int         lat;
    logic [6:0] ep;
    lat = sel ? LAT_S : LAT_D;
    kick(rw, a, w, c0);
    if (abortAt == 0 && resetAt == 0) begin
      sb.push_back('{doneCyc: c0 + lat, rdata: (rw ? rdVal : expRd)});
      if (rw) expRd = rdVal;
    end
    for (int r = 1; r < lat; r++) begin
      adInV = (expPins(r, 1'b1) == 7'b0011010) ? rdVal : ~rdVal;
      ep = expPins(r, rw);
      chk("pins", pins, ep);
      if (ep[2]) chk("adOut", adOut, ep[3] ? w : a);
      if (r == abortAt) begin
        abortV = 1'b1;
        @(negedge clkL);
        abortV = 1'b0;
        chk("abortIdle", pins, IDLE_PINS);
        chk("abortRdata", rdataObs, expRd);
        $display("txn aborted cyc=%0d", cyc);
        return;
      end
      if (r == resetAt) begin
        resetL = 1'b1;
        #1;
        chk("rstIdle", pins, IDLE_PINS);
        chk("rstRdata", rdataObs, 0);
        expRd = 8'h00;
        $display("txn reset cyc=%0d", cyc);
        @(negedge clkL);
        resetL = 1'b0;
        return;
      end
      @(negedge clkL);
    end
    @(negedge clkL);
    chk("postIdle", pins, IDLE_PINS);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    repeat (2) @(negedge clkL);
    chk("resetPins", pins, IDLE_PINS);
    chk("resetRdata", rdataObs, 0);
    chk("resetPinsS", {s.CS, s.RD, s.WR, s.AD, s.ad_oe, s.busy, s.done}, IDLE_PINS);
    resetL = 1'b0;

    // Write, started in the first cycle after reset release; then a read.
    runCycle(1'b0, 8'h21, 8'h45, 8'h00, 0, 0);
    runCycle(1'b1, 8'h30, 8'h00, 8'hA7, 0, 0);

    // start held high: second cycle accepted from the IDLE after DONE; busy pulses ignored.
    rwV = 1'b0; addrV = 8'h10; wdataV = 8'h11; startReq = 1'b1; c0 = cyc;
    sb.push_back('{doneCyc: c0 + 23, rdata: expRd});
    sb.push_back('{doneCyc: c0 + 47, rdata: expRd});
    for (int r = 1; r <= 55; r++) begin
      @(negedge clkL);
      if (r == 5) addrV = 8'h99;
      if (r == 6) chk("latchedAddr", adOut, 8'h10);
      if (r == 24) chk("b2bIdle", pins, IDLE_PINS);
      if (r == 25) chk("b2bRestart", pins, expPins(1, 1'b0));
      if (r == 26) chk("b2bNewAddr", adOut, 8'h99);
      if (r == 30) startReq = 1'b0;
      if (r == 35) startReq = 1'b1;
      if (r == 39) startReq = 1'b0;
    end

    // Abort in the third A_PW cycle of a read; no done may follow.
    runCycle(1'b1, 8'h40, 8'h00, 8'h5E, 5, 0);
    repeat (30) @(negedge clkL);
    chk("abortHold", rdataObs, 8'hA7);

    // Reset during D_PW of a read, then a write right after release.
    runCycle(1'b1, 8'h50, 8'h00, 8'h66, 0, 17);
    runCycle(1'b0, 8'h77, 8'h88, 8'h00, 0, 0);

    // Minimum timing on the second DUT.
    sel = 1'b1;
    runCycle(1'b0, 8'h12, 8'h34, 8'h00, 0, 0);
    runCycle(1'b1, 8'h56, 8'h00, 8'hC3, 0, 0);
    repeat (3) @(negedge clkL);

    chk("sbEmpty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtc_bus_cycle_gen.md
RTC_BUS_CYCLE_GEN -- requirements
Module: rtc_bus_cycle_gen

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
- DATA_W, 8, width of the multiplexed address/data bus.
- T_SU, 2, setup-phase length in clkL cycles, legal 1..255.
- T_PW, 6, strobe-phase length in clkL cycles, legal 1..255.
- T_HD, 2, hold-phase length in clkL cycles, legal 1..255.
- T_GAP, 4, address-to-data gap length in clkL cycles, legal 1..255.

REQ-002 Ports SHALL be (one per line: name, direction, width, meaning):
- clkL, in, 1, clock.
- resetL, in, 1, reset: asynchronous, active-high.
- start, in, 1, request a bus cycle; sampled only in IDLE.
- rw, in, 1, cycle type: 1 = read, 0 = write; latched with start.
- abort, in, 1, terminate the current cycle.
- addr, in, DATA_W, RTC register address; latched with start.
- wdata, in, DATA_W, write data; latched with start.
- ad_in, in, DATA_W, bus value from the pad.
- ad_out, out, DATA_W, bus value to the pad.
- ad_oe, out, 1, pad output enable.
- rdata, out, DATA_W, captured read data.
- busy, out, 1, a cycle is in progress.
- done, out, 1, one-cycle completion pulse.
- CS, out, 1, chip select, active low.
- RD, out, 1, read strobe, active low.
- WR, out, 1, write strobe, active low.
- AD, out, 1, 0 = address phase, 1 = data phase.

Function
REQ-003 The FSM SHALL use these states: IDLE, A_SU, A_PW, A_HD, GAP, D_PW, D_HD, DONE.
REQ-004 A single 8-bit phase counter SHALL time every phase; it loads on phase entry and moves to the next state after exactly the parameter count of cycles.
REQ-005 CS, RD, WR, AD, ad_oe, ad_out, busy and done SHALL be decoded from registered state only, with no combinational path from any input.
REQ-006 In IDLE: CS=RD=WR=1, AD=1, ad_oe=0, busy=0.
REQ-007 In IDLE, start=1 and abort=0 at an edge SHALL latch addr, wdata and rw, then enter A_SU.
REQ-008 In A_SU, for T_SU cycles: AD=0, ad_oe=1, ad_out=latched addr, CS=WR=RD=1.
REQ-009 In A_PW, for T_PW cycles: AD=0, ad_oe=1, CS=0, WR=0, RD=1. This is the address-latch strobe for both read and write.
REQ-010 In A_HD, for T_HD cycles: same as A_SU.
REQ-011 In GAP, for T_GAP cycles: AD=1, CS=RD=WR=1. On a write, ad_oe=1 and ad_out=latched wdata. On a read, ad_oe=0.
REQ-012 In D_PW, for T_PW cycles: CS=0 and AD=1. On a read, RD=0, WR=1, ad_oe=0. On a write, WR=0, RD=1, ad_oe=1, ad_out=wdata.
REQ-013 On a read, rdata SHALL load ad_in at the clock edge that ends the last D_PW cycle.
REQ-014 rdata SHALL hold its value otherwise, including through writes and aborts.
REQ-015 In D_HD, for T_HD cycles: CS=RD=WR=1, AD=1, and ad_oe as in GAP.
REQ-016 DONE SHALL last exactly one cycle with done=1 and busy=1, then return to IDLE.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 Latency SHALL be fixed: start accepted at edge k gives done=1 during cycle k+1+T_SU+2*T_PW+2*T_HD+T_GAP (k+23 with default parameters).
REQ-019 start while busy=1 SHALL be ignored; nothing is queued.
REQ-020 A new start in the cycle after DONE SHALL be accepted, so back-to-back cycles are allowed.
REQ-021 abort=1 in any non-IDLE state SHALL force IDLE at the next edge, with no done pulse and rdata unchanged.
REQ-022 abort=1 together with start=1 in IDLE SHALL be a no-op.
REQ-023 CS, RD and WR SHALL never be 0 in the same cycle that AD changes value.
REQ-024 RD and WR SHALL never both be 0.

Reset
REQ-025 resetL=1 SHALL immediately force IDLE, counter=0, rdata=0, latches=0, CS=RD=WR=AD=1, ad_oe=0, busy=0, done=0.
REQ-026 A reset during any phase SHALL abandon the cycle with no done pulse.
REQ-027 The first cycle after reset release SHALL accept start.

Verification
REQ-028 Write test, defaults: addr=0x21, wdata=0x45, rw=0, start at edge 0. Required: ad_out=0x21 with WR=0 for cycles 3..8, then ad_out=0x45 with WR=0 and AD=1 for cycles 15..20, then done=1 at cycle 23.
REQ-029 Read test, defaults: rw=1, ad_in=0xA7 during D_PW. Required: RD=0 for 6 cycles, ad_oe=0 from GAP onward, rdata=0xA7 at done.
REQ-030 Back-to-back test: start held high continuously. Required: a second cycle begins the cycle after DONE, and the start pulses issued while busy produce no extra cycles.
REQ-031 Abort test: abort=1 during the third A_PW cycle. Required: IDLE outputs next cycle, no done pulse, rdata unchanged.
REQ-032 Reset test: resetL pulsed during D_PW of a read. Required: immediate idle outputs and rdata=0.
REQ-033 Parameter sweep with T_SU=T_PW=T_HD=T_GAP=1. Required: done at cycle 7, and the strobe, AD and RD/WR rules of REQ-023 and REQ-024 hold on every cycle.
